multicycle_main_fsm: RTL
========================

// Module: multicycle_main_fsm
// PURPOSE
//  Main control FSM for the multicycle RV32I core: it sequences each instruction over several clocks from the 7-bit opcode.
//  It drives the datapath mux selects and write strobes. It also generates ImmSrc.
//  Adds a memory req/ready handshake with a bounded wait, plus illegal-opcode and bus-timeout trapping.
//  Sits between the instruction register and the datapath; ALU decoder and branch AND-gate stay external.
// PARAMETERS
//  OP_W      7   opcode width
//  WAIT_MAX  15  max cycles mem_req may stay unanswered before bus error (1..255)
//  CNT_W     8   wait-counter width; must hold WAIT_MAX
// PORTS
//  clk        in   1   core clock, all state changes on rising edge
//  reset_n    in   1   synchronous active-low reset
//  op         in   7   opcode from IR (instr[6:0])
//  mem_ready  in   1   memory completes current request this cycle
//  mem_req    out  1   memory access in progress (FETCH/MEMREAD/MEMWRITE)
//  AdrSrc     out  1   0=PC, 1=ALUOut to memory address
//  IRWrite    out  1   load IR/OldPC
//  PCUpdate   out  1   unconditional PC load
//  Branch     out  1   conditional PC load (ANDed with Zero outside)
//  RegWrite   out  1   register-file write
//  MemWrite   out  1   data-memory write
//  ALUSrcA    out  2   00=PC 01=OldPC 10=RD1
//  ALUSrcB    out  2   00=RD2 01=ImmExt 10=const 4
//  ALUOp      out  2   00=add 01=sub 10=funct-decoded
//  ResultSrc  out  2   00=ALUOut 01=Data 10=ALUResult 11=ImmExt
//  ImmSrc     out  3   comb. from op: 000 I, 001 S, 010 B, 011 J, 100 U; 000 otherwise
//  illegal    out  1   sticky: undecodable opcode seen
//  bus_err    out  1   sticky: memory wait exceeded WAIT_MAX
// BEHAVIOUR
//  Reset: state=FETCH, wait counter=0, illegal=0, bus_err=0. Reset is sampled only on a clk edge.
//   While reset_n=0, every Moore output is forced to 0 (incl. mem_req). Reset mid-instruction aborts it; no write strobes.
//  Signals not listed per state are 0. Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111, lui 0110111.
//  FETCH    : mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
//             IRWrite=PCUpdate=mem_ready (pulse only on the completing cycle). Next state: DECODE on mem_ready, else stay.
//  DECODE   : ALUSrcA=01 ALUSrcB=01 ALUOp=00. Branches by op:
//             lw/sw->MEMADR; R->EXECR; I->EXECI; beq->BEQ; jal->JAL; lui->LUIWB (macro only); else ->TRAP, illegal<=1.
//  MEMADR   : ALUSrcA=10 ALUSrcB=01 ALUOp=00; lw->MEMREAD, sw->MEMWRITE.
//  MEMREAD  : mem_req=1, AdrSrc=1, ResultSrc=00; ->MEMWB on mem_ready.
//  MEMWRITE : mem_req=1, AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready; ->FETCH on mem_ready.
//  MEMWB    : ResultSrc=01 RegWrite=1 ->FETCH.
//  EXECR    : ALUSrcA=10 ALUSrcB=00 ALUOp=10 ->ALUWB.   EXECI: ALUSrcA=10 ALUSrcB=01 ALUOp=10 ->ALUWB.
//  ALUWB    : ResultSrc=00 RegWrite=1 ->FETCH.
//  BEQ      : ALUSrcA=10 ALUSrcB=00 ALUOp=01 ResultSrc=00 Branch=1 ->FETCH.
//  JAL      : ALUSrcA=01 ALUSrcB=10 ALUOp=00 ResultSrc=00 PCUpdate=1 ->ALUWB.
//  TRAP     : all strobes 0, mem_req=0; absorbing until reset.
//  Wait counter: cleared on every state change.
//   Increments each cycle mem_req=1 && !mem_ready, saturating at WAIT_MAX.
//   If the count equals WAIT_MAX and mem_ready=0: go to TRAP, bus_err<=1, with no strobe that cycle.
//   mem_ready arriving on the same cycle as the limit wins: normal completion, no bus_err.
//  mem_ready outside memory states is ignored. Zero-wait memory (mem_ready tied 1) gives the classic 3/4/5-cycle CPI.
// CONFIGURATION
//  MC_LUI_EN defined  : op 0110111 -> DECODE->LUIWB (ResultSrc=11 RegWrite=1) ->FETCH; ImmSrc=100 for lui.
//  MC_LUI_EN undefined: LUIWB state absent; op 0110111 is illegal (->TRAP, illegal=1); ImmSrc never 100.
// TESTING
//  1 reset_n=0 for 2 clk mid-MEMWRITE -> all outputs 0; after release, FETCH with mem_req=1, illegal=bus_err=0.
//  2 mem_ready=1 constant; lw, sw, add, addi, beq, jal -> cycles/instr 5,4,4,4,3,4; exactly 1 IRWrite per instr.
//  3 lw with mem_ready delayed 3 cycles in MEMREAD -> stays MEMREAD 4 cycles; MEMWB RegWrite=1 exactly once.
//  4 WAIT_MAX=4, FETCH with mem_ready=0 -> TRAP at 5th cycle, bus_err=1.
//    Repeat with mem_ready=1 on that cycle -> DECODE, bus_err=0.
//  5 op=1111111 -> TRAP after DECODE, illegal=1, no RegWrite/MemWrite thereafter until reset.
//  6 op=0110111: with MC_LUI_EN -> ResultSrc=11 RegWrite=1, ImmSrc=100, 3 cycles.
//    Without MC_LUI_EN -> TRAP, illegal=1.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core with a bounded memory handshake and trap state.
// Optional LUI write-back path is enabled by defining MC_LUI_EN.
module multicycle_main_fsm #(
  parameter int OP_W     = 7,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            AdrSrc,
  output logic            IRWrite,
  output logic            PCUpdate,
  output logic            Branch,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ResultSrc,
  output logic [2:0]      ImmSrc,
  output logic            illegal,
  output logic            bus_err
);

  localparam logic [OP_W-1:0] OP_LW  = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_R   = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_I   = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(7'b1100011);
  localparam logic [OP_W-1:0] OP_JAL = OP_W'(7'b1101111);
  localparam logic [OP_W-1:0] OP_LUI = OP_W'(7'b0110111);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
`ifdef MC_LUI_EN
    S_LUIWB,
`endif
    S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             mem_state;
  logic             timeout;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // ready on the limit cycle counts as completion, so only an unanswered limit cycle times out
  assign timeout   = mem_state && !mem_ready && (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ResultSrc = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite  = 1'b1;
          PCUpdate = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_R)            state_d = S_EXECR;
        else if (op == OP_I)            state_d = S_EXECI;
        else if (op == OP_BEQ)          state_d = S_BEQ;
        else if (op == OP_JAL)          state_d = S_JAL;
`ifdef MC_LUI_EN
        else if (op == OP_LUI)          state_d = S_LUIWB;
`endif
        else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = !timeout;
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
        state_d  = S_ALUWB;
      end
`ifdef MC_LUI_EN
      S_LUIWB: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
`endif
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    if (timeout) begin
      state_d   = S_TRAP;
      bus_err_d = 1'b1;
    end

    if (state_d != state_q) cnt_d = '0;
    else if (mem_state && !mem_ready && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);

    // outputs are held quiet for the whole reset interval, not just after the first edge
    if (!reset_n) begin
      mem_req   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCUpdate  = 1'b0;
      Branch    = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      ResultSrc = 2'b00;
    end
  end

  assign illegal = illegal_q && reset_n;
  assign bus_err = bus_err_q && reset_n;

  always_comb begin
    ImmSrc = 3'b000;
    if (op == OP_SW)       ImmSrc = 3'b001;
    else if (op == OP_BEQ) ImmSrc = 3'b010;
    else if (op == OP_JAL) ImmSrc = 3'b011;
`ifdef MC_LUI_EN
    else if (op == OP_LUI) ImmSrc = 3'b100;
`endif
  end

endmodule
